// File: rtl/qu_issue_sched.sv
// Reservation-station issue scheduler: per-port round-robin pick of ready entries, registered issue.
// Optional issue/blocked performance counters are enabled with `define QU_ISSUE_PERF_CNT_EN.
module qu_issue_sched #(
    parameter int RS_DEPTH       = 16,
    parameter int NUM_PORTS      = 4,
    parameter int RS_ADDR_WIDTH  = $clog2(RS_DEPTH),
    parameter int PORT_SEL_WIDTH = $clog2(NUM_PORTS)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic [RS_DEPTH-1:0]                 entry_valid,
    input  logic [RS_DEPTH-1:0]                 entry_ready,
    input  logic [RS_DEPTH*PORT_SEL_WIDTH-1:0]  entry_port,
    input  logic [NUM_PORTS-1:0]                port_rdy,
    output logic [NUM_PORTS-1:0]                issue_vld,
    output logic [NUM_PORTS*RS_ADDR_WIDTH-1:0]  issue_addr,
    output logic [RS_DEPTH-1:0]                 issue_clr,
`ifdef QU_ISSUE_PERF_CNT_EN
    output logic [31:0]                         perf_issue_cnt,
    output logic [31:0]                         perf_blk_cnt,
`endif
    output logic [RS_DEPTH-1:0]                 inflight
);

    logic [NUM_PORTS-1:0]                    issue_vld_q;
    logic [NUM_PORTS-1:0][RS_ADDR_WIDTH-1:0] issue_addr_q;
    logic [RS_DEPTH-1:0]                     issue_clr_q;
    logic [RS_DEPTH-1:0]                     inflight_q;
    logic [NUM_PORTS-1:0][RS_ADDR_WIDTH-1:0] ptr_q;

    logic [NUM_PORTS-1:0][RS_DEPTH-1:0]      cand;
    logic [NUM_PORTS-1:0]                    sel_vld;
    logic [NUM_PORTS-1:0][RS_ADDR_WIDTH-1:0] sel_idx;
    logic [NUM_PORTS-1:0]                    issue_en;
    logic [RS_DEPTH-1:0]                     issue_clr_d;

    assign issue_vld  = issue_vld_q;
    assign issue_addr = issue_addr_q;
    assign issue_clr  = issue_clr_q;
    assign inflight   = inflight_q;

    always_comb begin
        cand = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                cand[p][i] = entry_valid[i] & entry_ready[i] & ~inflight_q[i] &
                             (entry_port[i*PORT_SEL_WIDTH +: PORT_SEL_WIDTH] == PORT_SEL_WIDTH'(p));
            end
        end
    end

    // Scan from the far end back toward ptr so the candidate closest to ptr is assigned last and wins.
    always_comb begin
        sel_vld     = '0;
        sel_idx     = '0;
        issue_en    = '0;
        issue_clr_d = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int k = RS_DEPTH - 1; k >= 0; k--) begin
                if (cand[p][ptr_q[p] + RS_ADDR_WIDTH'(k)]) begin
                    sel_vld[p] = 1'b1;
                    sel_idx[p] = ptr_q[p] + RS_ADDR_WIDTH'(k);
                end
            end
            issue_en[p] = sel_vld[p] & port_rdy[p] & ~flush;
            if (issue_en[p]) begin
                issue_clr_d[sel_idx[p]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            issue_vld_q  <= '0;
            issue_addr_q <= '0;
            issue_clr_q  <= '0;
            inflight_q   <= '0;
            ptr_q        <= '0;
        end else if (flush) begin
            issue_vld_q  <= '0;
            issue_clr_q  <= '0;
            inflight_q   <= '0;
            ptr_q        <= '0;
        end else begin
            issue_vld_q <= issue_en;
            issue_clr_q <= issue_clr_d;
            // An entry being issued is valid, so the clear and set terms never target the same bit.
            inflight_q  <= (inflight_q & entry_valid) | issue_clr_d;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (issue_en[p]) begin
                    issue_addr_q[p] <= sel_idx[p];
                    ptr_q[p]        <= sel_idx[p] + RS_ADDR_WIDTH'(1);
                end
            end
        end
    end

`ifdef QU_ISSUE_PERF_CNT_EN
    logic [31:0] perf_issue_cnt_q;
    logic [31:0] perf_blk_cnt_q;
    logic [31:0] issue_pop;
    logic        any_blk;

    always_comb begin
        issue_pop = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            issue_pop = issue_pop + 32'(issue_en[p]);
        end
        any_blk = |(sel_vld & ~port_rdy);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_issue_cnt_q <= '0;
            perf_blk_cnt_q   <= '0;
        end else begin
            perf_issue_cnt_q <= perf_issue_cnt_q + issue_pop;
            if (any_blk) begin
                perf_blk_cnt_q <= perf_blk_cnt_q + 32'd1;
            end
        end
    end

    assign perf_issue_cnt = perf_issue_cnt_q;
    assign perf_blk_cnt   = perf_blk_cnt_q;
`endif

endmodule

// File: tb/tb_qu_issue_sched.sv
// Directed bench for qu_issue_sched: reset, single issue, round-robin wrap, parallel issue,
// back-pressure and flush, each with hand-computed expected outputs.
module tb_qu_issue_sched;

    localparam int RS_DEPTH  = 16;
    localparam int NUM_PORTS = 4;
    localparam int AW        = 4;
    localparam int PW        = 2;

    logic                         clk;
    logic                         rst;
    logic                         flush;
    logic [RS_DEPTH-1:0]          entry_valid;
    logic [RS_DEPTH-1:0]          entry_ready;
    logic [RS_DEPTH*PW-1:0]       entry_port;
    logic [NUM_PORTS-1:0]         port_rdy;
    logic [NUM_PORTS-1:0]         issue_vld;
    logic [NUM_PORTS*AW-1:0]      issue_addr;
    logic [RS_DEPTH-1:0]          issue_clr;
    logic [RS_DEPTH-1:0]          inflight;
`ifdef QU_ISSUE_PERF_CNT_EN
    logic [31:0]                  perf_issue_cnt;
    logic [31:0]                  perf_blk_cnt;
`endif

    int n_checks;
    int n_fails;

    qu_issue_sched #(
        .RS_DEPTH (RS_DEPTH),
        .NUM_PORTS(NUM_PORTS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .entry_valid(entry_valid),
        .entry_ready(entry_ready),
        .entry_port (entry_port),
        .port_rdy   (port_rdy),
        .issue_vld  (issue_vld),
        .issue_addr (issue_addr),
        .issue_clr  (issue_clr),
`ifdef QU_ISSUE_PERF_CNT_EN
        .perf_issue_cnt(perf_issue_cnt),
        .perf_blk_cnt  (perf_blk_cnt),
`endif
        .inflight   (inflight)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_entry(input int idx, input logic v, input logic r, input int p);
        entry_valid[idx]           = v;
        entry_ready[idx]           = r;
        entry_port[idx*PW +: PW]   = PW'(p);
    endtask

    task automatic apply_reset();
        entry_valid = '0;
        entry_ready = '0;
        entry_port  = '0;
        port_rdy    = 4'hF;
        flush       = 1'b0;
        rst         = 1'b0;
        tick();
        rst         = 1'b1;
    endtask

    // Checker
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] addr_of(input int p);
        return 32'(issue_addr[p*AW +: AW]);
    endfunction

    initial begin
        n_checks    = 0;
        n_fails     = 0;
        rst         = 1'b0;
        flush       = 1'b0;
        entry_valid = '1;
        entry_ready = '1;
        entry_port  = '0;
        port_rdy    = 4'hF;

        // Reset held with all inputs active
        for (int c = 0; c < 3; c++) begin
            tick();
            check_eq("rst_vld", 32'(issue_vld), 32'h0);
            check_eq("rst_clr", 32'(issue_clr), 32'h0);
            check_eq("rst_inflight", 32'(inflight), 32'h0);
            check_eq("rst_addr", 32'(issue_addr), 32'h0);
        end
        rst = 1'b1;
        tick();
        check_eq("post_rst_vld", 32'(issue_vld), 32'h1);
        check_eq("post_rst_addr0", addr_of(0), 32'd0);
        check_eq("post_rst_clr", 32'(issue_clr), 32'h0001);

        // Single issue: entry 5 -> port 2
        apply_reset();
        set_entry(5, 1'b1, 1'b1, 2);
        tick();
        check_eq("single_vld", 32'(issue_vld), 32'h4);
        check_eq("single_addr2", addr_of(2), 32'd5);
        check_eq("single_clr", 32'(issue_clr), 32'h0020);
        check_eq("single_inflight", 32'(inflight), 32'h0020);
        for (int c = 0; c < 2; c++) begin
            tick();
            check_eq("single_noreissue_vld", 32'(issue_vld), 32'h0);
            check_eq("single_noreissue_clr", 32'(issue_clr), 32'h0);
            check_eq("single_hold_inflight", 32'(inflight), 32'h0020);
        end
        entry_valid[5] = 1'b0;
        tick();
        check_eq("single_freed_inflight", 32'(inflight), 32'h0);
        check_eq("single_addr_hold", addr_of(2), 32'd5);

        // Round-robin and wrap on port 0
        apply_reset();
        set_entry(3, 1'b1, 1'b1, 0);
        set_entry(15, 1'b1, 1'b1, 0);
        tick();
        check_eq("rr_a_addr0", addr_of(0), 32'd3);
        check_eq("rr_a_clr", 32'(issue_clr), 32'h0008);
        entry_valid[3] = 1'b0;
        set_entry(2, 1'b1, 1'b1, 0);
        tick();
        check_eq("rr_b_vld", 32'(issue_vld), 32'h1);
        check_eq("rr_b_addr0", addr_of(0), 32'd15);
        check_eq("rr_b_inflight", 32'(inflight), 32'h8000);
        entry_valid[15] = 1'b0;
        set_entry(1, 1'b1, 1'b1, 0);
        tick();
        check_eq("rr_c_addr0", addr_of(0), 32'd1);
        check_eq("rr_c_clr", 32'(issue_clr), 32'h0002);
        entry_valid[1] = 1'b0;
        tick();
        check_eq("rr_d_addr0", addr_of(0), 32'd2);
        check_eq("rr_d_clr", 32'(issue_clr), 32'h0004);

        // Parallel issue on all four ports
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            set_entry(i, 1'b1, 1'b1, i);
        end
        tick();
        check_eq("par_vld", 32'(issue_vld), 32'hF);
        check_eq("par_addr", 32'(issue_addr), 32'h3210);
        check_eq("par_clr", 32'(issue_clr), 32'h000F);
`ifdef QU_ISSUE_PERF_CNT_EN
        check_eq("par_perf_issue", perf_issue_cnt, 32'd4);
`endif

        // Back-pressure on port 1; entry 3 becomes ready while blocked
        apply_reset();
        set_entry(7, 1'b1, 1'b1, 1);
        port_rdy = 4'b1101;
        for (int c = 0; c < 4; c++) begin
            if (c == 2) set_entry(3, 1'b1, 1'b1, 1);
            tick();
            check_eq("bp_vld", 32'(issue_vld), 32'h0);
            check_eq("bp_clr", 32'(issue_clr), 32'h0);
        end
`ifdef QU_ISSUE_PERF_CNT_EN
        check_eq("bp_perf_blk", perf_blk_cnt, 32'd4);
`endif
        port_rdy = 4'hF;
        tick();
        check_eq("bp_early_vld", 32'(issue_vld), 32'h2);
        check_eq("bp_early_addr1", addr_of(1), 32'd3);
        entry_valid[3] = 1'b0;
        tick();
        check_eq("bp_rel_vld", 32'(issue_vld), 32'h2);
        check_eq("bp_rel_addr1", addr_of(1), 32'd7);
        check_eq("bp_rel_clr", 32'(issue_clr), 32'h0080);

        // Flush
        apply_reset();
        set_entry(9, 1'b1, 1'b1, 0);
        tick();
        check_eq("fl_pre_inflight", 32'(inflight), 32'h0200);
        set_entry(10, 1'b1, 1'b1, 0);
        flush = 1'b1;
        tick();
        check_eq("fl_vld", 32'(issue_vld), 32'h0);
        check_eq("fl_clr", 32'(issue_clr), 32'h0);
        check_eq("fl_inflight", 32'(inflight), 32'h0);
        flush = 1'b0;
        entry_valid[9] = 1'b0;
        set_entry(4, 1'b1, 1'b1, 1);
        tick();
        check_eq("fl_post_vld", 32'(issue_vld), 32'h3);
        check_eq("fl_post_addr0", addr_of(0), 32'd10);
        check_eq("fl_post_addr1", addr_of(1), 32'd4);
        check_eq("fl_post_clr", 32'(issue_clr), 32'h0410);

        // Final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/qu_issue_sched.md
Name: qu_issue_sched

Overview:
Issue scheduler for the reservation station (RS). Each cycle it selects, per execution port, one valid entry whose operands are ready, and drives the matching RS read address to that execution unit. It also tells the RS which entries were issued so they can be freed. It sits between the RS and the NUM_PORTS execution units, after rename.

Parameters:
RS_DEPTH, 16, number of RS entries (power of two, ≥4)
NUM_PORTS, 4, number of execution ports / RS read ports
RS_ADDR_WIDTH, $clog2(RS_DEPTH), RS entry index width
PORT_SEL_WIDTH, $clog2(NUM_PORTS), width of per-entry port field

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-low reset
flush  in  1  pipeline flush (branch/jump/exception); cancels issue
entry_valid  in  RS_DEPTH  RS entry occupied
entry_ready  in  RS_DEPTH  all source operands of entry available
entry_port  in  RS_DEPTH*PORT_SEL_WIDTH  target port of entry i at bits [i*PORT_SEL_WIDTH +: PORT_SEL_WIDTH]
port_rdy  in  NUM_PORTS  execution unit p can accept an op this cycle
issue_vld  out  NUM_PORTS  registered; op issued to port p
issue_addr  out  NUM_PORTS*RS_ADDR_WIDTH  registered; RS index for port p, drives the RS read address
issue_clr  out  RS_DEPTH  registered one-cycle pulse; RS must free entry i
inflight  out  RS_DEPTH  entries issued but not yet freed by RS

Behaviour:
- Reset (rst==0 at clk edge): issue_vld=0, issue_addr=0, issue_clr=0, inflight=0, all round-robin pointers ptr[p]=0. Reset has priority over flush and issue.
- Candidate for port p: entry_valid[i] & entry_ready[i] & (entry_port[i]==p) & ~inflight[i].
- Selection is combinational. Port p scans indices ptr[p], ptr[p]+1, … modulo RS_DEPTH; the first candidate wins.
- Each entry targets exactly one port, so ports never conflict; up to NUM_PORTS issues per cycle.
- An issue on port p occurs iff a winner exists, port_rdy[p]==1 and flush==0.
- Latency is 1 cycle: issue_vld[p]/issue_addr[p] are registered and valid the cycle after selection. issue_clr[winner] pulses in the same cycle as issue_vld.
- When no issue occurs on port p: issue_vld[p]=0 and issue_addr[p] holds its last value.
- On issue, ptr[p] <= (winner+1) mod RS_DEPTH. It wraps at RS_DEPTH-1 → 0 and is unchanged when there is no issue.
- inflight[i] is set on the edge where entry i issues. It clears on any edge where entry_valid[i]==0 (RS freed the entry), or on flush. Set and clear cannot coincide because a candidate requires valid=1.
- The RS must drop entry_valid[i] no earlier than the cycle it sees issue_clr[i]. inflight prevents re-issue in that gap.
- flush==1: no issue that cycle. Next cycle issue_vld=0 and issue_clr=0. inflight cleared, all ptr reset to 0.
- Empty RS or no ready entries: no issue; pointers hold.
- port_rdy low while a candidate exists: candidate waits and the pointer holds. A later port_rdy high issues the same entry, unless an earlier-scanned candidate became ready in the meantime.

Optional Feature:
QU_ISSUE_PERF_CNT_EN.
- Defined: adds output perf_issue_cnt (32 bits), the total number of ops issued across all ports (+ popcount of issues per cycle).
- Defined: adds output perf_blk_cnt (32 bits), which increments each cycle in which some port has a candidate but port_rdy==0.
- Both counters reset to 0, wrap modulo 2^32, and are not affected by flush.
- Undefined: both ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset: hold rst=0 for 3 cycles with all inputs active -> issue_vld=0, issue_clr=0, inflight=0 throughout; first issue occurs no earlier than 1 cycle after rst=1.
- Single issue: entry 5 valid+ready, port 2, port_rdy=4'hF -> next cycle issue_vld=4'b0100, issue_addr[2]=5, issue_clr=16'h0020, inflight[5]=1; entry not re-issued while entry_valid[5] stays 1.
- Round-robin/wrap on port 0: entries 3 and 15 ready, ptr[0]=0 -> entry 3 issues, ptr[0]=4. Entry 15 issues next, ptr[0]=0. Newly ready entry 1 issues next.
- Parallel issue: entries 0,1,2,3 ready with ports 0,1,2,3 -> one cycle later issue_vld=4'hF and addrs 0,1,2,3.
- Back-pressure: entry 7 ready for port 1 with port_rdy[1]=0 for 4 cycles -> no issue and ptr[1] unchanged. port_rdy[1]=1 -> entry 7 issues next cycle.
- Flush: entry 9 inflight, entry 10 ready; flush=1 for 1 cycle -> next cycle issue_vld=0, inflight=0, ptrs=0. Entry 10 issues on the cycle after flush deasserts.
